// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller: request/grant/rvalid data-memory port.
// Optional MISALIGN_TRAP_EN: misaligned accesses are trapped instead of issued.
module mem_access_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_load_type,
    input  logic [1:0]        req_store_type,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              mem_req,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_we,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_byte_sel,
    output logic [2:0]        rsp_load_type,
    output logic              store_done
`ifdef MISALIGN_TRAP_EN
    ,
    output logic              misalign_err
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_e;

    state_e              state_q, state_d;
    logic                is_store_q, is_store_d;
    logic [2:0]          ld_type_q, ld_type_d;
    logic [1:0]          byte_sel_q, byte_sel_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-3:0]   mem_addr_q, mem_addr_d;
    logic [3:0]          mem_we_q, mem_we_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic [1:0]          rsp_byte_sel_q, rsp_byte_sel_d;
    logic [2:0]          rsp_load_type_q, rsp_load_type_d;
    logic                store_done_q, store_done_d;

    logic                acc_store, acc_load, misaligned, accept;
    logic [3:0]          st_we;
    logic [31:0]         st_wdata;

    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && (state_q == IDLE);
    assign acc_store = (req_store_type != 2'd0);
    assign acc_load  = !acc_store && (req_load_type inside {[3'd1:3'd5]});

    always_comb begin
        st_we    = 4'b0000;
        st_wdata = req_wdata;
        case (req_store_type)
            2'd1: begin
                st_we    = 4'b0001 << req_addr[1:0];
                st_wdata = {4{req_wdata[7:0]}};
            end
            2'd2: begin
                st_we    = 4'b0011 << req_addr[1:0];
                st_wdata = {2{req_wdata[15:0]}};
            end
            2'd3: begin
                st_we    = 4'b1111;
                st_wdata = req_wdata;
            end
            default: ;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic misalign_err_q, misalign_err_d;

    always_comb begin
        misaligned = 1'b0;
        if (acc_store) begin
            misaligned = ((req_store_type == 2'd2) && req_addr[0]) ||
                         ((req_store_type == 2'd3) && (req_addr[1:0] != 2'd0));
        end else if (acc_load) begin
            misaligned = (((req_load_type == 3'd2) || (req_load_type == 3'd5)) && req_addr[0]) ||
                         ((req_load_type == 3'd3) && (req_addr[1:0] != 2'd0));
        end
    end

    assign misalign_err_d = accept && (acc_store || acc_load) && misaligned;
    assign misalign_err   = misalign_err_q;
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        is_store_d      = is_store_q;
        ld_type_d       = ld_type_q;
        byte_sel_d      = byte_sel_q;
        mem_req_d       = mem_req_q;
        mem_addr_d      = mem_addr_q;
        mem_we_d        = mem_we_q;
        mem_wdata_d     = mem_wdata_q;
        rsp_valid_d     = 1'b0;
        rsp_rdata_d     = rsp_rdata_q;
        rsp_byte_sel_d  = rsp_byte_sel_q;
        rsp_load_type_d = rsp_load_type_q;
        store_done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept && (acc_store || acc_load) && !misaligned) begin
                    state_d    = ISSUE;
                    mem_req_d  = 1'b1;
                    mem_addr_d = req_addr[ADDR_W-1:2];
                    is_store_d = acc_store;
                    if (acc_store) begin
                        mem_we_d    = st_we;
                        mem_wdata_d = st_wdata;
                    end else begin
                        mem_we_d   = 4'b0000;
                        ld_type_d  = req_load_type;
                        byte_sel_d = req_addr[1:0];
                    end
                end
            end
            ISSUE: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    if (is_store_q) begin
                        store_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        state_d = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                if (mem_rvalid) begin
                    rsp_valid_d     = 1'b1;
                    rsp_rdata_d     = mem_rdata;
                    rsp_byte_sel_d  = byte_sel_q;
                    rsp_load_type_d = ld_type_q;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            is_store_q      <= 1'b0;
            ld_type_q       <= '0;
            byte_sel_q      <= '0;
            mem_req_q       <= 1'b0;
            mem_addr_q      <= '0;
            mem_we_q        <= '0;
            mem_wdata_q     <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_byte_sel_q  <= '0;
            rsp_load_type_q <= '0;
            store_done_q    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_err_q  <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            is_store_q      <= is_store_d;
            ld_type_q       <= ld_type_d;
            byte_sel_q      <= byte_sel_d;
            mem_req_q       <= mem_req_d;
            mem_addr_q      <= mem_addr_d;
            mem_we_q        <= mem_we_d;
            mem_wdata_q     <= mem_wdata_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_rdata_q     <= rsp_rdata_d;
            rsp_byte_sel_q  <= rsp_byte_sel_d;
            rsp_load_type_q <= rsp_load_type_d;
            store_done_q    <= store_done_d;
`ifdef MISALIGN_TRAP_EN
            misalign_err_q  <= misalign_err_d;
`endif
        end
    end

    assign mem_req       = mem_req_q;
    assign mem_addr      = mem_addr_q;
    assign mem_we        = mem_we_q;
    assign mem_wdata     = mem_wdata_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_byte_sel  = rsp_byte_sel_q;
    assign rsp_load_type = rsp_load_type_q;
    assign store_done    = store_done_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized
// traffic against a behavioural model; honours MISALIGN_TRAP_EN when defined.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_load_type = '0;
    logic [1:0]  req_store_type = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_byte_sel;
    logic [2:0]  rsp_load_type;
    logic        store_done;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_load_type(req_load_type), .req_store_type(req_store_type),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_byte_sel(rsp_byte_sel), .rsp_load_type(rsp_load_type),
        .store_done(store_done)
`ifdef MISALIGN_TRAP_EN
        , .misalign_err(misalign_err)
`endif
    );

    task automatic cyc;
        @(negedge clk);
    endtask

    task automatic drive_req(input logic [2:0] lt, input logic [1:0] st,
                             input logic [31:0] a, input logic [31:0] wd);
        req_valid      = 1'b1;
        req_load_type  = lt;
        req_store_type = st;
        req_addr       = a;
        req_wdata      = wd;
    endtask

    // Byte lanes covered by the store: a window of the access size starting at the offset.
    function automatic logic [3:0] model_we(input int st, input int off);
        logic [3:0] we;
        int size;
        we = 4'b0000;
        if (st == 3) return 4'b1111;
        size = (st == 1) ? 1 : 2;
        for (int b = 0; b < 4; b++)
            if (b >= off && b < off + size) we[b] = 1'b1;
        return we;
    endfunction

    function automatic logic [31:0] model_wdata(input int st, input logic [31:0] wd);
        if (st == 1) return {24'd0, wd[7:0]} * 32'h01010101;
        if (st == 2) return {16'd0, wd[15:0]} * 32'h00010001;
        return wd;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        cyc();
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%0b exp=0", req_ready); end
        cyc();
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%0b exp=0", mem_req); end
        checks++; if (mem_we !== 4'd0 || mem_addr !== 30'd0 || mem_wdata !== 32'd0) begin
            failures++; $display("FAIL rst_mem_port we=%0h addr=%0h wdata=%0h exp=0", mem_we, mem_addr, mem_wdata); end
        checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_byte_sel !== 2'd0 || rsp_load_type !== 3'd0) begin
            failures++; $display("FAIL rst_rsp v=%0b d=%0h sel=%0d t=%0d exp=0", rsp_valid, rsp_rdata, rsp_byte_sel, rsp_load_type); end
        checks++; if (store_done !== 1'b0) begin failures++; $display("FAIL rst_store_done got=%0b exp=0", store_done); end
`ifdef MISALIGN_TRAP_EN
        checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL rst_misalign got=%0b exp=0", misalign_err); end
`endif
        rst = 1'b0;
        cyc();
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_after got=%0b exp=1", req_ready); end
    endtask

    task automatic test_nop;
        drive_req(3'd0, 2'd0, 32'h0000_0104, 32'h1234_5678);
        cyc();
        drive_req(3'd6, 2'd0, 32'h0000_0208, 32'h0);
        cyc();
        req_valid = 1'b0;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL nop_mem_req got=%0b exp=0", mem_req); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL nop_ready got=%0b exp=1", req_ready); end
        cyc();
        checks++; if (mem_req !== 1'b0 || rsp_valid !== 1'b0 || store_done !== 1'b0) begin
            failures++; $display("FAIL nop_activity req=%0b rsp=%0b sd=%0b exp=0", mem_req, rsp_valid, store_done); end
    endtask

    task automatic test_store_sb;
        drive_req(3'd0, 2'd1, 32'h0000_0103, 32'h0000_00AB);
        cyc();
        req_valid = 1'b0;
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL sb_req got=%0b exp=1", mem_req); end
        checks++; if (mem_addr !== 30'h40) begin failures++; $display("FAIL sb_addr got=%0h exp=40", mem_addr); end
        checks++; if (mem_we !== 4'b1000) begin failures++; $display("FAIL sb_we got=%b exp=1000", mem_we); end
        checks++; if (mem_wdata !== 32'hABABABAB) begin failures++; $display("FAIL sb_wdata got=%0h exp=ababab ab", mem_wdata); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL sb_busy_ready got=%0b exp=0", req_ready); end
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        checks++; if (store_done !== 1'b1 || req_ready !== 1'b1 || mem_req !== 1'b0) begin
            failures++; $display("FAIL sb_done sd=%0b rdy=%0b req=%0b exp=1,1,0", store_done, req_ready, mem_req); end
        cyc();
        checks++; if (store_done !== 1'b0) begin failures++; $display("FAIL sb_done_pulse got=%0b exp=0", store_done); end
    endtask

    task automatic test_lhu_wait;
        drive_req(3'd5, 2'd0, 32'h0000_0202, 32'h0);
        cyc();
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) cyc();
            checks++; if (mem_req !== 1'b1 || mem_addr !== 30'h80 || mem_we !== 4'd0) begin
                failures++; $display("FAIL lhu_hold%0d req=%0b addr=%0h we=%0h exp=1,80,0", k, mem_req, mem_addr, mem_we); end
        end
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL lhu_req_drop got=%0b exp=0", mem_req); end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEADBEEF;
        cyc();
        mem_rvalid = 1'b0;
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL lhu_rsp_valid got=%0b exp=1", rsp_valid); end
        checks++; if (rsp_rdata !== 32'hDEADBEEF || rsp_byte_sel !== 2'd2 || rsp_load_type !== 3'd5) begin
            failures++; $display("FAIL lhu_rsp d=%0h sel=%0d t=%0d exp=deadbeef,2,5", rsp_rdata, rsp_byte_sel, rsp_load_type); end
        cyc();
        checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL lhu_rsp_hold v=%0b d=%0h exp=0,deadbeef", rsp_valid, rsp_rdata); end
    endtask

    task automatic test_back_to_back;
        logic [2:0]  lt [3] = '{3'd3, 3'd0, 3'd3};
        logic [1:0]  st [3] = '{2'd0, 2'd3, 2'd0};
        logic [31:0] ad [3] = '{32'h0000_0100, 32'h0000_0204, 32'h0000_0308};
        logic [31:0] dt [3] = '{32'h1111_2222, 32'hCAFE_F00D, 32'h3333_4444};
        drive_req(lt[0], st[0], ad[0], dt[0]);
        for (int i = 0; i < 3; i++) begin
            cyc();
            req_valid = 1'b0;
            checks++; if (mem_req !== 1'b1 || mem_addr !== ad[i][31:2] || req_ready !== 1'b0) begin
                failures++; $display("FAIL b2b_issue%0d req=%0b addr=%0h rdy=%0b exp=1,%0h,0", i, mem_req, mem_addr, req_ready, ad[i][31:2]); end
            checks++; if (mem_we !== ((st[i] != 0) ? 4'hF : 4'h0)) begin
                failures++; $display("FAIL b2b_we%0d got=%0h", i, mem_we); end
            mem_gnt = 1'b1;
            cyc();
            mem_gnt = 1'b0;
            if (st[i] != 0) begin
                checks++; if (store_done !== 1'b1 || req_ready !== 1'b1 || mem_wdata !== dt[i]) begin
                    failures++; $display("FAIL b2b_store%0d sd=%0b rdy=%0b wd=%0h exp=1,1,%0h", i, store_done, req_ready, mem_wdata, dt[i]); end
            end else begin
                checks++; if (req_ready !== 1'b0 || mem_req !== 1'b0) begin
                    failures++; $display("FAIL b2b_wait%0d rdy=%0b req=%0b exp=0,0", i, req_ready, mem_req); end
                mem_rvalid = 1'b1;
                mem_rdata  = dt[i];
                cyc();
                mem_rvalid = 1'b0;
                checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== dt[i] || req_ready !== 1'b1) begin
                    failures++; $display("FAIL b2b_rsp%0d v=%0b d=%0h rdy=%0b exp=1,%0h,1", i, rsp_valid, rsp_rdata, req_ready, dt[i]); end
            end
            if (i < 2) drive_req(lt[i+1], st[i+1], ad[i+1], dt[i+1]);
        end
        cyc();
    endtask

    task automatic test_rst_wait_rd;
        drive_req(3'd3, 2'd0, 32'h0000_0010, 32'h0);
        cyc();
        req_valid = 1'b0;
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rstwr_req got=%0b exp=0", mem_req); end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5A5A_5A5A;
        cyc();
        mem_rvalid = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0) begin
            failures++; $display("FAIL rstwr_stray v=%0b d=%0h exp=0,0", rsp_valid, rsp_rdata); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rstwr_ready got=%0b exp=1", req_ready); end
        drive_req(3'd1, 2'd0, 32'h0000_0021, 32'h0);
        cyc();
        req_valid = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 30'h8) begin
            failures++; $display("FAIL rstwr_next req=%0b addr=%0h exp=1,8", mem_req, mem_addr); end
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0077;
        cyc();
        mem_rvalid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h77 || rsp_byte_sel !== 2'd1) begin
            failures++; $display("FAIL rstwr_next_rsp v=%0b d=%0h sel=%0d exp=1,77,1", rsp_valid, rsp_rdata, rsp_byte_sel); end
        cyc();
    endtask

    task automatic test_lw_006;
        drive_req(3'd3, 2'd0, 32'h0000_0006, 32'h0);
        cyc();
        req_valid = 1'b0;
`ifdef MISALIGN_TRAP_EN
        checks++; if (misalign_err !== 1'b1 || mem_req !== 1'b0 || req_ready !== 1'b1) begin
            failures++; $display("FAIL lw6_trap err=%0b req=%0b rdy=%0b exp=1,0,1", misalign_err, mem_req, req_ready); end
        cyc();
        checks++; if (misalign_err !== 1'b0 || mem_req !== 1'b0) begin
            failures++; $display("FAIL lw6_trap_pulse err=%0b req=%0b exp=0,0", misalign_err, mem_req); end
`else
        checks++; if (mem_req !== 1'b1 || mem_addr !== 30'd1 || mem_we !== 4'd0) begin
            failures++; $display("FAIL lw6_issue req=%0b addr=%0h we=%0h exp=1,1,0", mem_req, mem_addr, mem_we); end
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BAD_F00D;
        cyc();
        mem_rvalid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_byte_sel !== 2'd2 || rsp_load_type !== 3'd3 || rsp_rdata !== 32'h0BADF00D) begin
            failures++; $display("FAIL lw6_rsp v=%0b sel=%0d t=%0d d=%0h exp=1,2,3,0badf00d", rsp_valid, rsp_byte_sel, rsp_load_type, rsp_rdata); end
        cyc();
`endif
    endtask

    task automatic test_random;
        logic [31:0] last_rdata, last_rdata_n;
        logic [1:0]  last_sel;
        logic [2:0]  last_type;
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        last_rdata = '0; last_sel = '0; last_type = '0;
        for (int t = 0; t < 80; t++) begin
            int unsigned kind, gd, rd;
            int sz;
            logic [2:0]  lt;
            logic [1:0]  st;
            logic [31:0] a, wd, rdat;
            logic [3:0]  exp_we;
            bit is_st, is_ld, trap;
            kind = $urandom_range(0, 9);
            gd   = $urandom_range(0, 3);
            rd   = $urandom_range(0, 2);
            a    = $urandom;
            wd   = $urandom;
            rdat = $urandom;
            if (kind < 4) begin
                st = 2'($urandom_range(1, 3));
                lt = 3'($urandom_range(0, 7));
            end else if (kind < 8) begin
                st = 2'd0;
                lt = 3'($urandom_range(1, 5));
            end else begin
                st = 2'd0;
                lt = (kind == 8) ? 3'd0 : 3'($urandom_range(6, 7));
            end
            is_st = (st != 2'd0);
            is_ld = !is_st && (lt >= 3'd1) && (lt <= 3'd5);
            if (is_st) sz = (st == 2'd1) ? 1 : (st == 2'd2) ? 2 : 4;
            else       sz = (lt == 3'd1 || lt == 3'd4) ? 1 : (lt == 3'd2 || lt == 3'd5) ? 2 : 4;
            trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
            trap = (is_st || is_ld) && ((int'(a[1:0]) % sz) != 0);
`endif
            checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rnd%0d_ready got=%0b exp=1", t, req_ready); end
            drive_req(lt, st, a, wd);
            cyc();
            req_valid = 1'b0;
            if (!(is_st || is_ld) || trap) begin
                checks++; if (mem_req !== 1'b0 || req_ready !== 1'b1 || store_done !== 1'b0 || rsp_valid !== 1'b0) begin
                    failures++; $display("FAIL rnd%0d_idle req=%0b rdy=%0b sd=%0b rv=%0b exp=0,1,0,0", t, mem_req, req_ready, store_done, rsp_valid); end
`ifdef MISALIGN_TRAP_EN
                checks++; if (misalign_err !== trap) begin
                    failures++; $display("FAIL rnd%0d_misalign got=%0b exp=%0b", t, misalign_err, trap); end
`endif
                mem_rvalid = 1'b1;
                mem_rdata  = rdat;
                cyc();
                mem_rvalid = 1'b0;
                checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== last_rdata) begin
                    failures++; $display("FAIL rnd%0d_stray v=%0b d=%0h exp=0,%0h", t, rsp_valid, rsp_rdata, last_rdata); end
            end else begin
                exp_we = is_st ? model_we(int'(st), int'(a[1:0])) : 4'd0;
                for (int k = 0; k <= int'(gd); k++) begin
                    if (k > 0) cyc();
                    checks++; if (mem_req !== 1'b1 || mem_addr !== a[31:2] || mem_we !== exp_we || req_ready !== 1'b0) begin
                        failures++; $display("FAIL rnd%0d_issue req=%0b addr=%0h we=%0h rdy=%0b exp=1,%0h,%0h,0", t, mem_req, mem_addr, mem_we, req_ready, a[31:2], exp_we); end
                    if (is_st) begin
                        checks++; if (mem_wdata !== model_wdata(int'(st), wd)) begin
                            failures++; $display("FAIL rnd%0d_wdata got=%0h exp=%0h", t, mem_wdata, model_wdata(int'(st), wd)); end
                    end
                end
                mem_gnt = 1'b1;
                cyc();
                mem_gnt = 1'b0;
                if (is_st) begin
                    checks++; if (store_done !== 1'b1 || req_ready !== 1'b1 || mem_req !== 1'b0 || rsp_rdata !== last_rdata) begin
                        failures++; $display("FAIL rnd%0d_store sd=%0b rdy=%0b req=%0b d=%0h exp=1,1,0,%0h", t, store_done, req_ready, mem_req, rsp_rdata, last_rdata); end
                end else begin
                    for (int k = 0; k <= int'(rd); k++) begin
                        if (k > 0) cyc();
                        checks++; if (mem_req !== 1'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
                            failures++; $display("FAIL rnd%0d_waitrd req=%0b rdy=%0b rv=%0b exp=0,0,0", t, mem_req, req_ready, rsp_valid); end
                    end
                    mem_rvalid = 1'b1;
                    mem_rdata  = rdat;
                    cyc();
                    mem_rvalid = 1'b0;
                    last_rdata_n = rdat;
                    last_rdata = last_rdata_n; last_sel = a[1:0]; last_type = lt;
                    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== last_rdata || rsp_byte_sel !== last_sel || rsp_load_type !== last_type || req_ready !== 1'b1) begin
                        failures++; $display("FAIL rnd%0d_rsp v=%0b d=%0h sel=%0d t=%0d rdy=%0b exp=1,%0h,%0d,%0d,1", t, rsp_valid, rsp_rdata, rsp_byte_sel, rsp_load_type, req_ready, last_rdata, last_sel, last_type); end
                end
                cyc();
                checks++; if (rsp_valid !== 1'b0 || store_done !== 1'b0 || rsp_byte_sel !== last_sel || rsp_load_type !== last_type) begin
                    failures++; $display("FAIL rnd%0d_after rv=%0b sd=%0b sel=%0d t=%0d exp=0,0,%0d,%0d", t, rsp_valid, store_done, rsp_byte_sel, rsp_load_type, last_sel, last_type); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_nop();
        test_store_sb();
        test_lhu_wait();
        test_back_to_back();
        test_rst_wait_rd();
        test_lw_006();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage load/store controller for the RISC-V pipeline CPU. It accepts one load or store per handshake from the EX/MEM boundary and builds the word address, byte write enables and lane-replicated store data. It drives a request/grant/read-valid data-memory port and returns the raw 32-bit loaded word, the byte offset and the load mode to the write-back data-extension stage. Pipeline stall is derived from `req_ready`.

## Interface
- `ADDR_W`, default 32: byte-address width; the memory word address is `ADDR_W-2` bits.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted this cycle when both valid and ready are high.
- `req_load_type` in 3: load mode. Encoding: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU.
- `req_store_type` in 2: store mode. Encoding: 0 none, 1 SB, 2 SH, 3 SW.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `mem_req` out 1: memory request; held until `mem_gnt`.
- `mem_addr` out ADDR_W-2: word address, equal to `req_addr[ADDR_W-1:2]`.
- `mem_we` out 4: byte write enables; 0 for loads.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_gnt` in 1: memory accepted the request.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in 32: read word.
- `rsp_valid` out 1: one-cycle pulse when the loaded word is available.
- `rsp_rdata` out 32: raw word.
- `rsp_byte_sel` out 2: `addr[1:0]` of the load.
- `rsp_load_type` out 3: load mode of the load.
- `store_done` out 1: one-cycle pulse when a store is granted.
- `misalign_err` out 1: one-cycle pulse. Present only with the macro in Configuration.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD. `req_ready` is 1 only in IDLE.
- IDLE, accept with `req_store_type` != 0: the access is a store and `req_load_type` is ignored. Latch address, `mem_we` and `mem_wdata`, then go to ISSUE.
- IDLE, accept with `req_load_type` 1..5: latch address, mode and byte offset; set `mem_we` to 0; go to ISSUE.
- IDLE, accept with both types 0, or load type 6/7: NOP. Stay in IDLE with no memory activity and no pulse.
- Store byte enables:
  - SB: `4'b0001 << addr[1:0]`.
  - SH: `(4'b0011 << addr[1:0])`, truncated to 4 bits.
  - SW: `4'b1111`.
- Store data:
  - SB: `{4{wdata[7:0]}}`.
  - SH: `{2{wdata[15:0]}}`.
  - SW: `wdata`.
- ISSUE: `mem_req`=1 with stable address, enables and data.
  - On `mem_gnt`, a store pulses `store_done` next cycle and goes to IDLE.
  - On `mem_gnt`, a load goes to WAIT_RD.
- WAIT_RD: on `mem_rvalid`, register `mem_rdata` into `rsp_rdata`, pulse `rsp_valid` next cycle, go to IDLE.
- `rsp_rdata`, `rsp_byte_sel` and `rsp_load_type` hold their value until the next load response.
- `mem_rvalid` outside WAIT_RD is ignored.
- Memory contract: `mem_rvalid` comes at least one cycle after `mem_gnt`, with exactly one `mem_rvalid` per granted load.

## Timing
- Reset values: state IDLE; `req_ready`=0 during the reset cycle and 1 after; `mem_req`=0; `mem_we`=0; `mem_addr`=0; `mem_wdata`=0; `rsp_valid`=0; `rsp_rdata`=0; `rsp_byte_sel`=0; `rsp_load_type`=0; `store_done`=0; `misalign_err`=0.
- All outputs are registered except `req_ready`, which is decoded from state.
- Request accepted at edge N: `mem_req` is high from cycle N+1.
- Zero-wait memory (`gnt` in N+1, `rvalid` in N+2): `rsp_valid` at N+3, and the next request is accepted at the N+3 edge.
- Store with `gnt` in N+1: `store_done` and `req_ready` are high in N+2.
- Back-to-back throughput: load, 1 per 3 cycles minimum; store, 1 per 2 cycles.
- `rst` mid-access: return to IDLE at that edge and drop `mem_req`. A later stray `mem_rvalid` produces no `rsp_valid`.

## Configuration
- `MISALIGN_TRAP_EN` defined: an access is misaligned when LH/LHU/SH has `addr[0]`=1, or LW/SW has `addr[1:0]` != 0.
  - A misaligned access is accepted but not issued.
  - `misalign_err` pulses in cycle N+1 and the FSM stays in IDLE.
- `MISALIGN_TRAP_EN` undefined:
  - The `misalign_err` port does not exist.
  - A misaligned access issues normally with truncated byte enables, e.g. SH at offset 3 gives `mem_we`=`4'b1000`.

## Test plan
- SB, addr `0x103`, wdata `0xAB`, `gnt` immediate → `mem_addr`=`0x40`, `mem_we`=`4'b1000`, `mem_wdata`=`0xABABABAB`, `store_done` at N+2.
- LHU, addr `0x202`, `gnt` held low 3 cycles then `rvalid` data `0xDEADBEEF` → `mem_req` stable for 4 cycles, `rsp_rdata`=`0xDEADBEEF`, `rsp_byte_sel`=2, `rsp_load_type`=5, `rsp_valid` for exactly one cycle.
- Back-to-back LW, SW, LW with a zero-wait memory → `req_ready` low in each busy cycle, every access issued in order, no lost responses.
- `rst` asserted while in WAIT_RD, then `mem_rvalid` arrives → `mem_req`=0 after the reset edge, no `rsp_valid`, next request accepted.
- LW at addr `0x006`:
  - with `MISALIGN_TRAP_EN`: `misalign_err` pulse, no `mem_req`.
  - without: `mem_addr`=1, normal response with `rsp_byte_sel`=2.
- `req_valid` with both types 0 → no `mem_req`, `req_ready` stays 1.
